// File: rtl/lbp_pkg.sv
// lbp_pkg: FSM states, LBP neighbour bit indices and the address-width helper shared by lbp_stream
package lbp_pkg;
    typedef enum logic [2:0] {IDLE, READ, DRAIN, FLUSH, DONE} state_t;
    localparam int G_TL = 0, G_T = 1, G_TR = 2, G_L = 3, G_R = 4, G_BL = 5, G_B = 6, G_BR = 7;
    function automatic int calc_aw(input int w, input int h);
        return $clog2(w * h);
    endfunction
endpackage

// File: rtl/lbp_line_buf.sv
// lbp_line_buf: two IMG_W x DW line buffers at column x; row2/row1 = rows y-2/y-1, we shifts din in
module lbp_line_buf #(
    parameter int IMG_W = 128,
    parameter int DW = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(IMG_W)-1:0] x,
    input  logic [DW-1:0]            din,
    output logic [DW-1:0]            row2,
    output logic [DW-1:0]            row1
);
    logic [DW-1:0] lb1 [IMG_W];
    logic [DW-1:0] lb0 [IMG_W];
    assign row2 = lb1[x];
    assign row1 = lb0[x];
    always_ff @(posedge clk)
        if (we) begin
            lb1[x] <= lb0[x];
            lb0[x] <= din;
        end
endmodule

// File: rtl/lbp_stream.sv
// lbp_stream: streaming 3x3 LBP; clk, reset (async low), gray_ready/thr/gray_req/gray_addr/gray_data read side, lbp_valid/lbp_addr/lbp_data write side, finish
module lbp_stream
    import lbp_pkg::*;
#(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int DW = 8,
    parameter int AW = calc_aw(IMG_W, IMG_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          gray_ready,
    input  logic [DW-1:0] thr,
    output logic          gray_req,
    output logic [AW-1:0] gray_addr,
    input  logic [DW-1:0] gray_data,
    output logic          lbp_valid,
    output logic [AW-1:0] lbp_addr,
    output logic [7:0]    lbp_data,
    output logic          finish
);
    localparam int XW = $clog2(IMG_W);
    localparam logic [AW-1:0] LAST = AW'(IMG_W * IMG_H - 1);
    localparam logic [AW-1:0] ROW = AW'(IMG_W);
    localparam logic [AW-1:0] ROW2 = AW'(2 * IMG_W);
    localparam logic [AW-1:0] FBASE = AW'((IMG_H - 1) * IMG_W);
    state_t state, state_n;
    logic [AW-1:0] rd_cnt, cnt, arr_a, pa;
    logic [XW-1:0] arr_x, px;
    logic pv, issue, wr_px;
    logic [DW-1:0] thr_r, lb_r2, lb_r1;
    logic [DW-1:0] win [3][3];
    logic [DW-1:0] g [8];
    logic [DW:0] level;
    logic [7:0] code;
    assign issue = state == READ && gray_ready;
    // pa/px describe the pixel that arrived last edge; its window centre is (px-1, row-1)
    assign wr_px = pv && pa >= ROW;
    lbp_line_buf #(.IMG_W(IMG_W), .DW(DW)) u_lb (
        .clk(clk),
        .we(gray_req),
        .x(arr_x),
        .din(gray_data),
        .row2(lb_r2),
        .row1(lb_r1)
    );
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = gray_ready ? READ : IDLE;
            READ:    state_n = (issue && rd_cnt == LAST) ? DRAIN : READ;
            DRAIN:   state_n = (cnt == AW'(1)) ? FLUSH : DRAIN;
            FLUSH:   state_n = (cnt == AW'(IMG_W - 1)) ? DONE : FLUSH;
            default: state_n = DONE;
        endcase
    end
    always_comb begin
        g[G_TL] = win[0][0];
        g[G_T]  = win[0][1];
        g[G_TR] = win[0][2];
        g[G_L]  = win[1][0];
        g[G_R]  = win[1][2];
        g[G_BL] = win[2][0];
        g[G_B]  = win[2][1];
        g[G_BR] = win[2][2];
        level = {1'b0, win[1][1]} + {1'b0, thr_r};
        for (int k = 0; k < 8; k++) code[k] = {1'b0, g[k]} >= level;
    end
    always_ff @(posedge clk)
        if (gray_req) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb_r2;
            win[1][2] <= lb_r1;
            win[2][2] <= gray_data;
        end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            rd_cnt <= '0;
            cnt <= '0;
            thr_r <= '0;
            arr_a <= '0;
            arr_x <= '0;
            pa <= '0;
            px <= '0;
            pv <= 1'b0;
            gray_req <= 1'b0;
            gray_addr <= '0;
            lbp_valid <= 1'b0;
            lbp_addr <= '0;
            lbp_data <= '0;
            finish <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= (state_n != state) ? '0 : cnt + 1'b1;
            if (state == IDLE && gray_ready) thr_r <= thr;
            gray_req <= issue;
            if (issue) begin
                gray_addr <= rd_cnt;
                rd_cnt <= rd_cnt + 1'b1;
            end
            pv <= gray_req;
            if (gray_req) begin
                pa <= arr_a;
                px <= arr_x;
                arr_a <= arr_a + 1'b1;
                arr_x <= (arr_x == XW'(IMG_W - 1)) ? '0 : arr_x + 1'b1;
            end
            lbp_valid <= wr_px || state == FLUSH;
            if (state == FLUSH) begin
                lbp_addr <= FBASE + cnt;
                lbp_data <= '0;
            end else if (wr_px) begin
                lbp_addr <= (px == '0) ? pa - 1'b1 : pa - ROW - 1'b1;
                lbp_data <= (px <= XW'(1) || pa < ROW2) ? 8'h00 : code;
            end
            finish <= finish || state == DONE;
        end
    end
endmodule

// File: tb/tb_lbp_stream.sv
// tb_lbp_stream: randomized scoreboard bench for lbp_stream against a plain-arithmetic LBP model
module tb_lbp_stream;
    localparam int W = 16, H = 12, N = W * H, AW = $clog2(N);
    localparam int SW = 4, SH = 3, SN = SW * SH, SAW = $clog2(SN);
    localparam int DX [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    localparam int DY [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    typedef struct {int a; int d;} wr_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic gray_ready = 1'b0;
    logic gray_req, lbp_valid, finish;
    logic [7:0] thr = 8'h00;
    logic [7:0] gray_data = 8'h00;
    logic [7:0] lbp_data;
    logic [AW-1:0] gray_addr, lbp_addr;
    logic s_reset = 1'b0;
    logic s_ready = 1'b0;
    logic s_req, s_valid, s_finish;
    logic [9:0] s_thr = 10'h0;
    logic [9:0] s_data = 10'h0;
    logic [SAW-1:0] s_addr, s_waddr;
    logic [7:0] s_wdata;

    int img [];
    int simg [];
    wr_t exp_q [$];
    int checks = 0, fails = 0, cyc = 0, writes = 0, stall = 0;
    bit go = 0, sgo = 0, prev_ready = 1;
    int s_seen [SN];
    int s_val [SN];

    lbp_stream #(.IMG_W(W), .IMG_H(H), .DW(8)) dut (
        .clk(clk), .reset(reset), .gray_ready(gray_ready), .thr(thr),
        .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data),
        .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data), .finish(finish)
    );
    lbp_stream #(.IMG_W(SW), .IMG_H(SH), .DW(10)) dut_s (
        .clk(clk), .reset(s_reset), .gray_ready(s_ready), .thr(s_thr),
        .gray_req(s_req), .gray_addr(s_addr), .gray_data(s_data),
        .lbp_valid(s_valid), .lbp_addr(s_waddr), .lbp_data(s_wdata), .finish(s_finish)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    function automatic int ref_code(input int im [], input int w, input int h, input int x, input int y, input int t);
        int c, r;
        if (x == 0 || y == 0 || x == w - 1 || y == h - 1) return 0;
        c = im[y * w + x];
        r = 0;
        for (int k = 0; k < 8; k++)
            if (im[(y + DY[k]) * w + x + DX[k]] >= c + t) r += 1 << k;
        return r;
    endfunction

    // memory models, gray_ready driver and the request-while-not-ready check
    always @(negedge clk) begin
        if (!prev_ready) check("req_while_not_ready", int'(gray_req), 0);
        gray_data = gray_req ? 8'(img[gray_addr]) : 8'h00;
        gray_ready = go && (stall == 0 || (stall == 1 && cyc % 3 != 0) || (stall == 2 && $urandom_range(0, 3) != 0));
        prev_ready = gray_ready;
        s_data = s_req ? 10'(simg[s_addr]) : 10'h0;
        s_ready = sgo;
    end

    // scoreboard monitor
    always @(negedge clk) begin
        wr_t e;
        if (lbp_valid) begin
            writes++;
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL extra_write: addr %0d data %0d, no write expected", lbp_addr, lbp_data);
            end else begin
                e = exp_q.pop_front();
                check("lbp_addr", int'(lbp_addr), e.a);
                check("lbp_data", int'(lbp_data), e.d);
            end
        end
        if (s_valid) begin
            s_seen[s_waddr]++;
            s_val[s_waddr] = s_wdata;
        end
    end

    task automatic build_main(input int t);
        wr_t e;
        int x, y;
        exp_q.delete();
        for (int p = 0; p < N; p++) begin
            x = p % W;
            y = p / W;
            if (y >= 1) begin
                e.a = (y - 1) * W + (x == 0 ? W - 1 : x - 1);
                e.d = ref_code(img, W, H, e.a % W, e.a / W, t);
                exp_q.push_back(e);
            end
        end
        for (int i = 0; i < W; i++) begin
            e.a = (H - 1) * W + i;
            e.d = 0;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst_gray_req", int'(gray_req), 0);
        check("rst_gray_addr", int'(gray_addr), 0);
        check("rst_lbp_valid", int'(lbp_valid), 0);
        check("rst_lbp_addr", int'(lbp_addr), 0);
        check("rst_lbp_data", int'(lbp_data), 0);
        check("rst_finish", int'(finish), 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic run_frame(input string name, input int t, input int stl);
        int t0, tf;
        build_main(t);
        thr = 8'(t);
        stall = stl;
        writes = 0;
        t0 = -1;
        tf = -1;
        go = 1;
        for (int i = 0; i < 6 * N; i++) begin
            @(posedge clk);
            #1;
            if (i == 30) thr = ~thr;
            if (gray_req && t0 < 0) t0 = cyc;
            if (finish) begin
                tf = cyc;
                break;
            end
        end
        check({name, "_finish"}, int'(finish), 1);
        if (stl == 0) check({name, "_latency"}, tf - t0, N + 2 + W);
        check({name, "_writes"}, writes, N);
        check({name, "_pending"}, exp_q.size(), 0);
        go = 0;
        do_reset();
    endtask

    task automatic run_small(input string name, input int t);
        s_thr = 10'(t);
        for (int a = 0; a < SN; a++) s_seen[a] = 0;
        sgo = 1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (s_finish) break;
        end
        check({name, "_finish"}, int'(s_finish), 1);
        for (int a = 0; a < SN; a++) begin
            check({name, "_once"}, s_seen[a], 1);
            check({name, "_code"}, s_val[a], ref_code(simg, SW, SH, a % SW, a / SW, t));
        end
        sgo = 0;
        @(posedge clk);
        #2 s_reset = 1'b0;
        repeat (2) @(posedge clk);
        #2 s_reset = 1'b1;
    endtask

    initial begin
        int t;
        img = new[N];
        simg = new[SN];
        repeat (2) @(posedge clk);
        #1;
        check("init_gray_req", int'(gray_req), 0);
        check("init_lbp_valid", int'(lbp_valid), 0);
        check("init_finish", int'(finish), 0);
        #1 reset = 1'b1;
        s_reset = 1'b1;
        for (int p = 0; p < N; p++) img[p] = (p % W + p / W) & 255;
        run_frame("ramp", 0, 0);
        run_frame("ramp_stall", 0, 1);
        for (int p = 0; p < N; p++) img[p] = 8'h80;
        run_frame("c80_t0", 0, 0);
        run_frame("c80_t1", 1, 0);
        for (int p = 0; p < N; p++) img[p] = 8'hFF;
        run_frame("sat_t1", 1, 0);
        for (int p = 0; p < N; p++) img[p] = $urandom_range(0, 255);
        t = $urandom_range(0, 20);
        run_frame("rand", t, 2);
        for (int p = 0; p < N; p++) img[p] = (p % W + p / W) & 255;
        build_main(0);
        thr = 8'h00;
        stall = 0;
        go = 1;
        for (int i = 0; i < 4 * N && gray_addr < AW'(100); i++) @(posedge clk);
        check("midrst_progress", int'(gray_addr >= AW'(100)), 1);
        go = 0;
        do_reset();
        exp_q.delete();
        run_frame("after_reset", 0, 0);
        for (int a = 0; a < SN; a++) simg[a] = 10'h3FF;
        run_small("s_sat", 0);
        for (int a = 0; a < SN; a++) simg[a] = $urandom_range(0, 1023);
        run_small("s_rand", $urandom_range(0, 30));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/lbp_stream.md
# lbp_stream

Parametrised streaming Local Binary Pattern engine, the next-generation LBP core for the image-processing datapath. It reads a raster image of any size and pixel width from the gray-image memory, one pixel per cycle, with no re-reads: two line buffers and a 3x3 window replace per-pixel neighbourhood fetches. It writes one 8-bit LBP code per pixel to the LBP result memory, adds a programmable comparison threshold, and raises `finish` when the frame is complete.

## Interface
- `IMG_W`, 128, image width in pixels (>= 3)
- `IMG_H`, 128, image height in pixels (>= 3)
- `DW`, 8, gray pixel width in bits
- `AW`, $clog2(IMG_W*IMG_H), address width (derived; 14 at defaults)

- `clk` in 1: single clock, rising-edge
- `reset` in 1: asynchronous, active-low
- `gray_ready` in 1: gray memory available; engine issues requests only while high
- `thr` in DW: comparison threshold; sampled on frame start, held for the frame
- `gray_req` out 1: read request for `gray_addr`
- `gray_addr` out AW: pixel address, y*IMG_W + x
- `gray_data` in DW: read data; valid at the rising edge after the request edge
- `lbp_valid` out 1: result write strobe
- `lbp_addr` out AW: result address
- `lbp_data` out 8: LBP code
- `finish` out 1: frame done; held high until reset

## Operation
- Neighbour order, bit k = weight 2^k: g0 TL, g1 T, g2 TR, g3 L, g4 R, g5 BL, g6 B, g7 BR.
- Bit k = 1 iff g_k >= gc + thr. The sum is computed at DW+1 bits with no wrap, so gc+thr > 2^DW-1 gives bit 0.
- Border pixels (x=0, x=IMG_W-1, y=0, y=IMG_H-1) get code 0x00.
- Every address is written exactly once per frame: IMG_W*IMG_H writes in total.
- Read order is raster, addresses 0 .. IMG_W*IMG_H-1, each pixel read once.
- Line buffers: lb1 holds row y-2 and lb0 holds row y-1, each IMG_W x DW. On arrival of pixel (x,y):
  - the window shifts left;
  - the new right column is {lb1[x], lb0[x], data};
  - then lb1[x] <= lb0[x] and lb0[x] <= data.
- Write generated by arrival of (x,y), for y >= 1 only:
  - x = 0: address (IMG_W-1, y-1), data 0.
  - x = 1 or y = 1: address (x-1, y-1), data 0.
  - otherwise: address (x-1, y-1), data = computed code.
- After the last pixel, FLUSH writes 0 to the IMG_W addresses of row IMG_H-1, ascending.
- FSM:
  - IDLE: if gray_ready, sample thr and go to READ.
  - READ: issue one request per cycle while gray_ready. After the last address is issued, go to DRAIN.
  - DRAIN: 2 cycles, until the last computed write is out. Then go to FLUSH.
  - FLUSH: IMG_W cycles. Then go to DONE.
  - DONE: finish = 1, no activity until reset.

## Timing
- Reset values: gray_req=0, gray_addr=0, lbp_valid=0, lbp_addr=0, lbp_data=0, finish=0. FSM goes to IDLE and line buffer contents are don't-care.
- All outputs are registered.
- Request at edge t returns data captured at edge t+1. The corresponding lbp write is presented after edge t+2 and stays valid for one full cycle; the result memory samples it at the negedge.
- If gray_ready is low, no request is issued that cycle and gray_addr holds. A request already issued still returns data the next edge. Stalls insert bubbles (lbp_valid=0) and never drop or duplicate writes.
- Steady-state throughput: 1 pixel/cycle. Full frame with gray_ready constantly high: IMG_W*IMG_H + 2 + IMG_W cycles from first request to last write. finish rises on the edge after the last write.
- Reset asserted mid-frame: outputs clear immediately and in-flight data is discarded. The next frame restarts from address 0.
- thr changes mid-frame are ignored.

## Structure
- Package lbp_pkg:
  - FSM state enum (IDLE, READ, DRAIN, FLUSH, DONE);
  - neighbour index constants G_TL..G_BR;
  - constant function for AW.
- Sub-module lbp_line_buf (parameters IMG_W, DW): dual line buffer with one read/one write per cycle at column x. It returns {row y-2, row y-1} and updates both in the same cycle.
- The top level holds the FSM, x/y counters, window registers, comparator array and output registers.

## Test plan
- Defaults, gray = (x+y)&0xFF, thr=0, gray_ready steady high:
  - interior pixels whose 3x3 window does not wrap give 0xF4;
  - all borders give 0x00;
  - exactly 16384 lbp_valid pulses;
  - finish after 16384+2+128 cycles.
- Constant image 0x80: thr=0 gives all interior 0xFF; rerun after reset with thr=1 gives all interior 0x00.
- Saturation: image all 0xFF, thr=1 gives interior 0x00; DW=10, image all 0x3FF, thr=0 gives interior 0xFF.
- Scenario 1 with gray_ready low every third cycle:
  - results identical to scenario 1;
  - gray_req never high in a cycle where gray_ready was low at the preceding negedge.
- IMG_W=4, IMG_H=3:
  - 12 writes, each address once;
  - only addresses 5 and 6 carry computed codes; all others 0x00.
- Reset pulled low at pixel 5000:
  - all outputs 0 within the same cycle;
  - after release, a full frame reproduces scenario 1 exactly.
